// File: rtl/hec_rx_chk_pkg.sv
// Shared definitions for the header-error-check receive path:
// FSM state encoding, HEC width and the HEC generator polynomial.
package hec_rx_chk_pkg;

  localparam int HEC_W = 8;

  // g(D) = D^8 + D^7 + D^5 + D^2 + D + 1, with the D^8 term implicit
  localparam logic [HEC_W-1:0] HEC_POLY = 8'hA7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_HEC  = 2'd2,
    ST_DONE = 2'd3
  } hec_state_e;

endpackage

// File: rtl/hec_rx_chk_lfsr_step.sv
// hec_lfsr_step: combinational next-state of the HEC LFSR.
// shin_o  : remainder after shifting a header bit into the divider.
// shout_o : remainder after shifting one HEC bit out (plain left shift).
// mism_o  : received HEC bit differs from the current remainder MSB.
module hec_lfsr_step
  import hec_rx_chk_pkg::*;
(
  input  logic [HEC_W-1:0] rem_i,
  input  logic             bit_i,
  output logic [HEC_W-1:0] shin_o,
  output logic [HEC_W-1:0] shout_o,
  output logic             mism_o
);

  logic fb;

  // Feedback taps come from the polynomial mask, so the divider tracks HEC_POLY
  always_comb begin
    fb      = bit_i ^ rem_i[HEC_W-1];
    shin_o  = {rem_i[HEC_W-2:0], 1'b0} ^ ({HEC_W{fb}} & HEC_POLY);
    shout_o = {rem_i[HEC_W-2:0], 1'b0};
    mism_o  = bit_i ^ rem_i[HEC_W-1];
  end

endmodule

// File: rtl/hec_rx_chk.sv
// hec_rx_chk: receives HDR_BITS header bits followed by an 8-bit HEC,
// rebuilds the header and reports whether the HEC matched.
// Optional build macro: HEC_FEC13_EN -- each logical bit is the majority
// vote of three consecutive accepted air bits (rate-1/3 repetition code).
module hec_rx_chk
  import hec_rx_chk_pkg::*;
#(
  parameter int HDR_BITS = 10
) (
  input  logic                clk_6M,
  input  logic                rstz,
  input  logic                start_p,
  input  logic [HEC_W-1:0]    hecremini,
  input  logic                abort_p,
  input  logic                rxbit_valid_p,
  input  logic                rxbit,
  output logic [HDR_BITS-1:0] hdr_out,
  output logic [HEC_W-1:0]    hecrem,
  output logic                hdr_valid_p,
  output logic                hec_ok,
  output logic                hec_err,
  output logic                busy
);

  // One counter serves both phases, so it must reach HDR_BITS-1 and HEC_W-1
  localparam int HDR_CW = (HDR_BITS > 1) ? $clog2(HDR_BITS) : 1;
  localparam int HEC_CW = $clog2(HEC_W);
  localparam int CNT_W  = (HDR_CW > HEC_CW) ? HDR_CW : HEC_CW;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] HEC_LAST = CNT_W'(HEC_W - 1);

  hec_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [HDR_BITS-1:0] hdr_q;
  logic [HEC_W-1:0]    rem_q;
  logic                mism_q;
  logic                ok_q;
  logic                err_q;
  logic                valid_q;
  logic                busy_q;

  logic                rx_acc;
  logic                lbit_vld;
  logic                lbit;
  logic [HEC_W-1:0]    rem_shin_d;
  logic [HEC_W-1:0]    rem_shout_d;
  logic                bit_mism_d;

  // Air bits only count while a header is being received and no control pulse is present
  assign rx_acc = rxbit_valid_p & ~start_p & ~abort_p &
                  ((state_q == ST_HDR) || (state_q == ST_HEC));

`ifdef HEC_FEC13_EN
  logic [1:0] trip_cnt_q;
  logic [1:0] trip_q;

  // Collect the first two bits of each triplet; the third completes the vote
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      trip_cnt_q <= 2'd0;
      trip_q     <= 2'b00;
    end else if (start_p || abort_p) begin
      trip_cnt_q <= 2'd0;
    end else if (rx_acc) begin
      if (trip_cnt_q == 2'd2) begin
        trip_cnt_q <= 2'd0;
      end else begin
        trip_q[trip_cnt_q[0]] <= rxbit;
        trip_cnt_q            <= trip_cnt_q + 2'd1;
      end
    end
  end

  assign lbit_vld = rx_acc & (trip_cnt_q == 2'd2);
  assign lbit     = (trip_q[0] & trip_q[1]) | (trip_q[0] & rxbit) | (trip_q[1] & rxbit);
`else
  assign lbit_vld = rx_acc;
  assign lbit     = rxbit;
`endif

  hec_lfsr_step u_step (
    .rem_i   (rem_q),
    .bit_i   (lbit),
    .shin_o  (rem_shin_d),
    .shout_o (rem_shout_d),
    .mism_o  (bit_mism_d)
  );

  // Reception FSM; abort has priority over start, start over normal sequencing
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      rem_q   <= '0;
      mism_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (abort_p) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_p) begin
      state_q <= ST_HDR;
      cnt_q   <= '0;
      hdr_q   <= '0;
      rem_q   <= hecremini;
      mism_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (lbit_vld) begin
            for (int i = 0; i < HDR_BITS; i++) begin
              if (cnt_q == CNT_W'(i)) hdr_q[i] <= lbit;
            end
            rem_q <= rem_shin_d;
            if (cnt_q == HDR_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_HEC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_HEC: begin
          if (lbit_vld) begin
            rem_q  <= rem_shout_d;
            mism_q <= mism_q | bit_mism_d;
            if (cnt_q == HEC_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              ok_q    <= ~(mism_q | bit_mism_d);
              err_q   <= mism_q | bit_mism_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hdr_out     = hdr_q;
  assign hecrem      = rem_q;
  assign hdr_valid_p = valid_q;
  assign hec_ok      = ok_q;
  assign hec_err     = err_q;
  assign busy        = busy_q;

endmodule

// File: doc/hec_rx_chk.md
HEC_RX_CHK -- requirements
Module: hec_rx_chk

Interface
REQ-001 Parameter: HDR_BITS, default 10, number of logical header bits before the 8-bit HEC.
REQ-002 clk_6M  input  1  system clock; all state updates on the rising edge.
REQ-003 rstz  input  1  reset, asynchronous, active-low.
REQ-004 start_p  input  1  one-cycle pulse: load LFSR seed and begin a new header reception.
REQ-005 hecremini  input  8  LFSR seed (UAP), sampled when start_p=1.
REQ-006 abort_p  input  1  one-cycle pulse: abandon reception and return to IDLE.
REQ-007 rxbit_valid_p  input  1  qualifies rxbit for one cycle.
REQ-008 rxbit  input  1  received air bit.
REQ-009 hdr_out  output  HDR_BITS  decoded header; first logical bit at hdr_out[0].
REQ-010 hecrem  output  8  current LFSR remainder.
REQ-011 hdr_valid_p  output  1  one-cycle pulse when the HEC check completes.
REQ-012 hec_ok  output  1  level: last completed check passed.
REQ-013 hec_err  output  1  level: last completed check failed.
REQ-014 busy  output  1  high in states HDR and HEC.

Function
REQ-015 The FSM SHALL have states IDLE, HDR, HEC, DONE; start_p moves any state to HDR.
REQ-016 A logical bit SHALL be produced per accepted rxbit_valid_p (see REQ-030 for FEC).
REQ-017 In HDR, each logical bit b SHALL update the LFSR: fb=b^hecrem[7]; hecrem <= {fb^hecrem[6], hecrem[5], fb^hecrem[4], hecrem[3], hecrem[2], fb^hecrem[1], fb^hecrem[0], fb} (g(D)=D^8+D^7+D^5+D^2+D+1).
REQ-018 In HDR, logical bit k (0-based) SHALL be written to hdr_out[k]; after HDR_BITS bits the FSM SHALL enter HEC.
REQ-019 In HEC, each logical bit SHALL be compared with hecrem[7], then hecrem <= {hecrem[6:0],1'b0}; any mismatch sets a sticky mismatch flag.
REQ-020 After 8 HEC bits the FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-021 In DONE, hdr_valid_p=1; hec_ok/hec_err SHALL be updated from the mismatch flag on the same edge that enters DONE and held until the next start_p.
REQ-022 start_p SHALL clear hec_ok, hec_err, hdr_out, the mismatch flag and bit counters, and load hecrem<=hecremini.
REQ-023 rxbit_valid_p in the same cycle as start_p, or while in IDLE/DONE, SHALL be ignored.
REQ-024 abort_p SHALL force IDLE without hdr_valid_p; hec_ok/hec_err stay 0; hdr_out and hecrem keep their values.
REQ-025 If start_p and abort_p coincide, abort_p SHALL win.
REQ-026 start_p while busy SHALL restart reception with no hdr_valid_p for the abandoned header.
REQ-027 hec_ok and hec_err SHALL never both be 1.

Reset
REQ-028 On rstz=0: state IDLE, hecrem=0, hdr_out=0, hdr_valid_p=0, hec_ok=0, hec_err=0, busy=0, all counters and flags 0.
REQ-029 Reset mid-reception SHALL discard the header; no pulse is produced after rstz rises.

Configuration
REQ-030 With HEC_FEC13_EN defined, each logical bit SHALL be the majority of 3 consecutive accepted rxbits (54 air bits for HDR_BITS=10); the triplet counter is cleared by start_p, abort_p and reset.
REQ-031 Without HEC_FEC13_EN, each accepted rxbit SHALL be one logical bit (18 air bits) and no triplet logic is present.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, HEC width constant 8 and polynomial constant 8'hA7.
REQ-033 The LFSR step SHALL be a sub-module hec_lfsr_step (combinational next-state for shift-in and shift-out); the FEC majority voter stays inline.

Verification
REQ-034 Seed 0x00, 10 header zeros, HEC 0x00 -> hdr_out=0, hdr_valid_p one cycle, hec_ok=1, hec_err=0.
REQ-035 Seed 0x00, header hdr_out[9]=1 only, HEC bits 1,0,1,0,0,1,1,1 -> hecrem=0xA7 entering HEC, hec_ok=1.
REQ-036 As REQ-035, but the last HEC bit is flipped -> hec_err=1, hec_ok=0, hdr_out=10'h200.
REQ-037 abort_p after 5 header bits, then start_p and a valid 18-bit frame -> exactly one hdr_valid_p, result of the second frame only.
REQ-038 HEC_FEC13_EN: REQ-035 frame with each bit tripled and one bit per triplet corrupted -> hec_ok=1; start_p+abort_p same cycle -> IDLE, busy=0.
REQ-039 rstz asserted during HEC state -> all outputs 0 immediately, no hdr_valid_p afterwards.
